rally_match_ctrl: RTL and testbench

- Parametrised match-sequencing controller for the two-player ball game.
- Runs intro and serve-wait timers, detects ball landing, awards points by court side, and checks match end.
- Supports pause and an optional win-by-two rule.
- Drives game_state, scores and last-point winner to the ball, player, npc and display blocks.

---
 rtl/rally_match_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rally_match_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rally_match_ctrl.sv
// Match sequencer for the two-player ball game: intro/serve timers, landing detection, scoring, match end.
// Optional win-by-two rule is enabled by defining RALLY_DEUCE_EN.
module rally_match_ctrl #(
  parameter int POS_W        = 12,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int INTRO_CYCLES = 100000000,
  parameter int SERVE_CYCLES = 50000000,
  parameter int FLOOR_Y      = 220,
  parameter int BALL_H       = 30,
  parameter int NET_X        = 160,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_sw,
  input  logic               pause,
  input  logic [POS_W-1:0]   ball_x,
  input  logic [POS_W-1:0]   ball_y,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] npc_score,
  output logic               who_win,
  output logic               point_pulse,
  output logic               match_over,
  output logic               match_winner
);

  // state   | meaning
  // S_INIT  | clear scores and winners
  // S_IDLE  | wait for start_sw=0
  // S_INTRO | intro timer
  // S_SERVE | serve-wait timer
  // S_PLAY  | rally in progress, watch for landing
  // S_SCORE | award the point by court side
  // S_CHECK | evaluate win condition
  // S_END   | match over, wait for start_sw=1
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_INTRO, S_SERVE, S_PLAY, S_SCORE, S_CHECK, S_END
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W:0]   WIN_L      = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   INTRO_LAST = CNT_W'(INTRO_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic               landed;
  logic               npc_side;
  logic [SCORE_W:0]   p_ext;
  logic [SCORE_W:0]   n_ext;
  logic               win;
  logic               winner;

  // Extra bit keeps a ball near the bottom of the coordinate range from wrapping.
  assign landed   = ({1'b0, ball_y} + (POS_W+1)'(BALL_H)) >= (POS_W+1)'(FLOOR_Y);
  assign npc_side = ball_x >= POS_W'(NET_X);
  assign p_ext    = {1'b0, player_score};
  assign n_ext    = {1'b0, npc_score};

`ifdef RALLY_DEUCE_EN
  always_comb begin
    win    = 1'b0;
    winner = who_win;
    if (player_score == SCORE_MAX || npc_score == SCORE_MAX) begin
      win = 1'b1;
      if (p_ext > n_ext)      winner = 1'b0;
      else if (n_ext > p_ext) winner = 1'b1;
      else                    winner = who_win;
    end else if (p_ext >= WIN_L && p_ext >= n_ext + (SCORE_W+1)'(2)) begin
      win    = 1'b1;
      winner = 1'b0;
    end else if (n_ext >= WIN_L && n_ext >= p_ext + (SCORE_W+1)'(2)) begin
      win    = 1'b1;
      winner = 1'b1;
    end
  end
`else
  always_comb begin
    win    = 1'b0;
    winner = who_win;
    if (p_ext >= WIN_L) begin
      win    = 1'b1;
      winner = 1'b0;
    end else if (n_ext >= WIN_L) begin
      win    = 1'b1;
      winner = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_INIT;
      timer        <= '0;
      game_state   <= 2'd0;
      player_score <= '0;
      npc_score    <= '0;
      who_win      <= 1'b0;
      point_pulse  <= 1'b0;
      match_over   <= 1'b0;
      match_winner <= 1'b0;
    end else begin
      point_pulse <= 1'b0;

      // game_state follows the state one cycle later; SCORE/CHECK keep the old value.
      case (state)
        S_INIT, S_IDLE, S_INTRO: game_state <= 2'd0;
        S_SERVE:                 game_state <= 2'd1;
        S_PLAY:                  game_state <= 2'd2;
        S_END:                   game_state <= 2'd3;
        default:                 ;
      endcase

      case (state)
        S_INIT: begin
          player_score <= '0;
          npc_score    <= '0;
          who_win      <= 1'b0;
          match_winner <= 1'b0;
          match_over   <= 1'b0;
          timer        <= '0;
          state        <= S_IDLE;
        end
        S_IDLE: begin
          if (!start_sw) state <= S_INTRO;
        end
        S_INTRO: begin
          if (!pause) begin
            if (timer == INTRO_LAST) begin
              timer <= '0;
              state <= S_SERVE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        S_SERVE: begin
          if (!pause) begin
            if (timer == SERVE_LAST) begin
              timer <= '0;
              state <= S_PLAY;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (!pause && landed) state <= S_SCORE;
        end
        S_SCORE: begin
          if (npc_side) begin
            if (npc_score != SCORE_MAX) npc_score <= npc_score + 1'b1;
            who_win <= 1'b1;
          end else begin
            if (player_score != SCORE_MAX) player_score <= player_score + 1'b1;
            who_win <= 1'b0;
          end
          point_pulse <= 1'b1;
          state       <= S_CHECK;
        end
        S_CHECK: begin
          if (win) begin
            match_over   <= 1'b1;
            match_winner <= winner;
            state        <= S_END;
          end else begin
            state <= S_SERVE;
          end
        end
        S_END: begin
          if (start_sw) begin
            match_over <= 1'b0;
            state      <= S_INIT;
          end
        end
        default: begin
          timer <= '0;
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rally_match_ctrl.sv
// Scoreboard bench for rally_match_ctrl: stimulus pushes expected points, serve lengths and match
// results; an independent monitor pops and compares when the DUT strobes them.
module tb_rally_match_ctrl;
  localparam int POS_W   = 12;
  localparam int SCORE_W = 4;
  localparam int WIN     = 3;
  localparam int INTRO   = 10;
  localparam int SERVE   = 5;
  localparam int SMAX    = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               reset, start_sw, pause;
  logic [POS_W-1:0]   ball_x, ball_y;
  logic [1:0]         game_state;
  logic [SCORE_W-1:0] player_score, npc_score;
  logic               who_win, point_pulse, match_over, match_winner;

  always #5 clk = ~clk;

  rally_match_ctrl #(
    .POS_W(POS_W), .SCORE_W(SCORE_W), .WIN_SCORE(WIN),
    .INTRO_CYCLES(INTRO), .SERVE_CYCLES(SERVE),
    .FLOOR_Y(220), .BALL_H(30), .NET_X(160), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .start_sw(start_sw), .pause(pause),
    .ball_x(ball_x), .ball_y(ball_y), .game_state(game_state),
    .player_score(player_score), .npc_score(npc_score), .who_win(who_win),
    .point_pulse(point_pulse), .match_over(match_over), .match_winner(match_winner)
  );

  typedef struct { int p; int n; int who; } pt_t;
  typedef struct { int winner; int p; int n; } end_t;

  pt_t  pq[$];
  end_t eq[$];
  int   sq[$];
  int   errors = 0;
  int   checks = 0;
  int   mp, mn, mwho;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: -1 while the match continues, otherwise the winning side.
  function automatic int match_end(int p, int n, int who);
`ifdef RALLY_DEUCE_EN
    if (p == SMAX || n == SMAX) return (p > n) ? 0 : (n > p) ? 1 : who;
    if (p >= WIN && p - n >= 2) return 0;
    if (n >= WIN && n - p >= 2) return 1;
    return -1;
`else
    if (p >= WIN) return 0;
    if (n >= WIN) return 1;
    return -1;
`endif
  endfunction

  function automatic int award(int x);
    pt_t  e;
    end_t f;
    int   r;
    if (x >= 160) begin
      mn = (mn < SMAX) ? mn + 1 : SMAX;
      mwho = 1;
    end else begin
      mp = (mp < SMAX) ? mp + 1 : SMAX;
      mwho = 0;
    end
    e.p = mp; e.n = mn; e.who = mwho;
    pq.push_back(e);
    r = match_end(mp, mn, mwho);
    if (r >= 0) begin
      f.winner = r; f.p = mp; f.n = mn;
      eq.push_back(f);
    end
    return r;
  endfunction

  initial begin : monitor
    int   run;
    logic [1:0] pgs;
    logic pmo;
    pt_t  e;
    end_t f;
    run = 0; pgs = 2'd0; pmo = 1'b0;
    forever begin
      @(negedge clk);
      if (point_pulse) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_point_pulse: got pulse expected none at %0t", $time);
        end else begin
          e = pq.pop_front();
          check("point_player_score", int'(player_score), e.p);
          check("point_npc_score", int'(npc_score), e.n);
          check("point_who_win", int'(who_win), e.who);
        end
      end
      if (match_over && !pmo) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_match_over: got match_over expected none at %0t", $time);
        end else begin
          f = eq.pop_front();
          check("end_winner", int'(match_winner), f.winner);
          check("end_player_score", int'(player_score), f.p);
          check("end_npc_score", int'(npc_score), f.n);
        end
      end
      if (game_state == 2'd1) begin
        run++;
      end else if (pgs == 2'd1) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_serve: got serve of %0d cycles expected none", run);
        end else begin
          check("serve_len", run, sq.pop_front());
        end
        run = 0;
      end
      pgs = game_state;
      pmo = match_over;
    end
  end

  task automatic wait_gs(int v, int budget, string name);
    int k;
    k = 0;
    while (int'(game_state) != v && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (int'(game_state) != v) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got game_state %0d expected %0d", name, game_state, v);
    end
  endtask

  task automatic wait_gs_ne(int v, int budget, string name);
    int k;
    k = 0;
    while (int'(game_state) == v && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (int'(game_state) == v) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got game_state %0d expected change", name, game_state);
    end
  endtask

  // Entered from IDLE. One edge moves IDLE->INTRO, INTRO lasts INTRO cycles,
  // and game_state lags by one more edge.
  task automatic start_match();
    int k;
    mp = 0; mn = 0; mwho = 0;
    start_sw = 1'b0;
    k = 0;
    while (game_state != 2'd1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("intro_len", k, INTRO + 2);
  endtask

  // Entered on the first sample of game_state==1, when the serve timer reads 1.
  task automatic serve_phase(bit do_pause, int plen);
    sq.push_back(do_pause ? SERVE + plen : SERVE);
    if (do_pause) begin
      @(negedge clk);
      pause = 1'b1;
      repeat (plen) @(negedge clk);
      pause = 1'b0;
    end
    wait_gs(2, 40, "serve_to_play");
  endtask

  task automatic rally(int x, bit edge_y, bit paused_land, output int ended);
    int quiet;
    quiet = $urandom_range(1, 3);
    for (int i = 0; i < quiet; i++) begin
      ball_x = POS_W'($urandom_range(0, 319));
      ball_y = edge_y ? POS_W'(189) : POS_W'($urandom_range(0, 189));
      @(negedge clk);
    end
    if (paused_land) begin
      pause  = 1'b1;
      ball_x = POS_W'(x);
      ball_y = POS_W'(200);
      repeat (3) @(negedge clk);
      ball_y = '0;
      pause  = 1'b0;
      @(negedge clk);
      check("paused_land_state", int'(game_state), 2);
      check("paused_land_player", int'(player_score), mp);
      check("paused_land_npc", int'(npc_score), mn);
    end
    ball_x = POS_W'(x);
    ball_y = edge_y ? POS_W'(190) : POS_W'($urandom_range(190, 4095));
    ended  = award(x);
    wait_gs_ne(2, 20, "play_exit");
    ball_y = '0;
  endtask

  task automatic end_phase(int winner);
    wait_gs(3, 20, "to_end");
    check("end_match_over", int'(match_over), 1);
    repeat ($urandom_range(2, 5)) @(negedge clk);
    check("end_hold_state", int'(game_state), 3);
    check("end_hold_player", int'(player_score), mp);
    check("end_hold_npc", int'(npc_score), mn);
    check("end_hold_winner", int'(match_winner), winner);
    start_sw = 1'b1;
    repeat (3) @(negedge clk);
    check("restart_state", int'(game_state), 0);
    check("restart_player", int'(player_score), 0);
    check("restart_npc", int'(npc_score), 0);
    check("restart_who_win", int'(who_win), 0);
    check("restart_match_over", int'(match_over), 0);
    check("restart_winner", int'(match_winner), 0);
  endtask

  task automatic run_match(bit directed);
    int xs[6];
    int ended, i, x;
    xs = '{100, 160, 100, 160, 100, 100};
    ended = -1;
    i = 0;
    start_match();
    while (ended < 0 && i < 40) begin
      if (directed) serve_phase(i == 0, 7);
      else          serve_phase($urandom_range(0, 9) < 3, $urandom_range(1, 8));
      if (directed) x = (i < 6) ? xs[i] : 100;
      else          x = ($urandom_range(0, 3) == 0) ? 159 + $urandom_range(0, 1) : $urandom_range(0, 319);
      rally(x, directed && i == 0, directed ? (i == 1) : ($urandom_range(0, 4) == 0), ended);
      i++;
    end
    end_phase(ended);
  endtask

  initial begin
    reset = 1'b1; start_sw = 1'b1; pause = 1'b0; ball_x = '0; ball_y = '0;
    repeat (3) @(negedge clk);
    check("reset_game_state", int'(game_state), 0);
    check("reset_player", int'(player_score), 0);
    check("reset_npc", int'(npc_score), 0);
    check("reset_who_win", int'(who_win), 0);
    check("reset_pulse", int'(point_pulse), 0);
    check("reset_match_over", int'(match_over), 0);
    check("reset_winner", int'(match_winner), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_match(1'b1);
    for (int m = 0; m < 4; m++) run_match(1'b0);

    // Reset while the DUT sits in the scoring state: no point may appear.
    start_match();
    serve_phase(1'b0, 0);
    ball_x = POS_W'(100);
    ball_y = POS_W'(200);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    ball_y = '0;
    mp = 0; mn = 0; mwho = 0;
    check("midscore_reset_state", int'(game_state), 0);
    check("midscore_reset_player", int'(player_score), 0);
    check("midscore_reset_npc", int'(npc_score), 0);
    check("midscore_reset_pulse", int'(point_pulse), 0);
    check("midscore_reset_over", int'(match_over), 0);
    repeat (4) @(negedge clk);
    check("midscore_after_pulse", int'(point_pulse), 0);
    check("midscore_after_player", int'(player_score), 0);
    check("midscore_after_npc", int'(npc_score), 0);
    check("pending_points", pq.size(), 0);
    check("pending_ends", eq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
